// File: rtl/game_flow_ctrl.sv
// Top-level rally game sequencer: start-button conditioning, lives tracking,
// death timing and fuel-block refill control.
// Optional build macro: EXTRA_LIFE_EN (level_clear grants a life and a refill).
module game_flow_ctrl #(
    parameter int unsigned LIVES_INIT  = 3,
    parameter int unsigned DEATH_TICKS = 100000000,
    parameter int unsigned CNT_W       = 27
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start_btn,
    input  logic       time_out,
    input  logic       crash,
    input  logic       level_clear,
    output logic       fuel_rst,
    output logic       play_en,
    output logic [1:0] lives,
    output logic [2:0] state,
    output logic       game_over
);

    typedef enum logic [2:0] {
        StIdle     = 3'd0,
        StRespawn  = 3'd1,
        StPlay     = 3'd2,
        StDying    = 3'd3,
        StGameOver = 3'd4
    } state_e;

    localparam logic [CNT_W-1:0] TimerLast = CNT_W'(DEATH_TICKS - 1);
    localparam logic [1:0]       LivesInit = 2'(LIVES_INIT);

    state_e           state_q, state_d;
    logic [1:0]       lives_q, lives_d;
    logic [CNT_W-1:0] timer_q, timer_d;
    logic [2:0]       sync_q, sync_d;
    logic             fuel_rst_q, fuel_rst_d;
    logic             play_en_q, play_en_d;
    logic             game_over_q, game_over_d;
    logic             start_evt;
    logic             bonus;

`ifndef EXTRA_LIFE_EN
    logic unused_level_clear;
    assign unused_level_clear = level_clear;
`endif

    // Two synchronizer stages plus one edge-detect stage; a held button fires once.
    always_comb begin
        sync_d    = {sync_q[1:0], start_btn};
        start_evt = sync_q[1] & ~sync_q[2];
    end

    // Next-state, lives, death timer and registered output decode.
    always_comb begin
        state_d = state_q;
        lives_d = lives_q;
        timer_d = '0;
        bonus   = 1'b0;

        unique case (state_q)
            StIdle, StGameOver: begin
                if (start_evt) begin
                    state_d = StRespawn;
                    lives_d = LivesInit;
                end
            end
            StRespawn: begin
                state_d = StPlay;
            end
            StPlay: begin
                // Death takes priority over a same-cycle level clear.
                if (time_out || crash) begin
                    state_d = StDying;
                end
`ifdef EXTRA_LIFE_EN
                else if (level_clear) begin
                    bonus = 1'b1;
                    if (lives_q != 2'd3) begin
                        lives_d = lives_q + 2'd1;
                    end
                end
`endif
            end
            StDying: begin
                if (timer_q == TimerLast) begin
                    lives_d = lives_q - 2'd1;
                    state_d = (lives_q == 2'd1) ? StGameOver : StRespawn;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        fuel_rst_d  = (state_d == StIdle) || (state_d == StRespawn) || bonus;
        play_en_d   = (state_d == StPlay);
        game_over_d = (state_d == StGameOver);
    end

    // State and registered outputs with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            lives_q     <= 2'd0;
            timer_q     <= '0;
            sync_q      <= 3'b000;
            fuel_rst_q  <= 1'b1;
            play_en_q   <= 1'b0;
            game_over_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            lives_q     <= lives_d;
            timer_q     <= timer_d;
            sync_q      <= sync_d;
            fuel_rst_q  <= fuel_rst_d;
            play_en_q   <= play_en_d;
            game_over_q <= game_over_d;
        end
    end

    assign fuel_rst  = fuel_rst_q;
    assign play_en   = play_en_q;
    assign lives     = lives_q;
    assign state     = state_q;
    assign game_over = game_over_q;

endmodule
